reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 16-entry, 4-wide in-order commit buffer between dispatch/execute and the architectural register file.
- Allocates a tag per dispatched instruction and captures execution results by tag.
- Retires up to 4 completed instructions per cycle in program order.
- Drives the register file write port (enable, target reg, data, writer tag); the register file compares the writer tag against the owner to clear busy.

Parameters:
- DEPTH, 16, ROB entries; power of two; equals 2^TAG_W.
- LANES, 4, allocate/complete/retire width.
- TAG_W, 4, tag width; matches register file owner width.
- DATA_W, 16, result width.
- REG_W, 4, architectural register index width.

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- alloc_valid[0:3]  in  1  dispatch lane k requests an entry.
- alloc_has_dest[0:3]  in  1  instruction writes a register.
- alloc_dest_reg[0:3]  in  REG_W  destination register.
- alloc_ready  out  1  all requested lanes accepted this cycle.
- alloc_tag[0:3]  out  TAG_W  tag assigned to lane k (combinational).
- complete_valid[0:3]  in  1  execution result valid.
- complete_tag[0:3]  in  TAG_W  entry being completed.
- complete_value[0:3]  in  DATA_W  result.
- flush  in  1  synchronous discard of all entries.
- retirement_write_data_enable[0:3]  out  1  register write strobe, lane i.
- retirement_target_reg[0:3]  out  REG_W  destination.
- retirement_write_data[0:3]  out  DATA_W  value.
- instruction_writer[0:3]  out  TAG_W  tag of the retiring instruction.
- retire_count  out  3  instructions retired last cycle (0..4).
- occupancy  out  5  live entries (0..16).
- empty  out  1  occupancy==0.
- full  out  1  occupancy==16.

Behaviour:
- State:
  - Per entry: valid, done, has_dest, dest_reg, value.
  - head and tail, TAG_W bits, wrap modulo DEPTH.
  - count, 5 bits.
- Reset (async): all valid/done=0, head=tail=count=0; all retirement outputs 0, retire_count=0.
- Allocation:
  - n = number of asserted alloc_valid lanes; lanes may be sparse.
  - alloc_tag[k] = tail + (number of valid lanes below k), mod 16.
  - alloc_ready = (count + n <= 16), using start-of-cycle count; same-cycle retirements do not free space.
  - On posedge with alloc_ready: write entries with valid=1, done=0; tail += n.
  - If !alloc_ready, nothing is allocated (all-or-nothing).
- Completion:
  - On posedge, for each complete_valid lane whose tag hits a valid entry: set done=1 and store value.
  - Hit on an invalid entry: ignored.
  - Two lanes with the same tag: highest lane wins.
- Retirement: registered, 1-cycle latency.
  - Retire slot i (0..3) covers entry head+i.
  - Slot i retires iff entries head..head+i are all valid && done; the first non-retiring slot stops the scan.
  - Next-cycle outputs for slot i: enable = retiring && has_dest; target_reg/data/writer = dest_reg/value/(head+i).
  - Non-retiring slots drive 0 on all four outputs.
  - head += r; valid cleared; retire_count = r.
- Simultaneous events:
  - count_next = count + n_accepted - r.
  - Allocation into an entry freed in the same cycle is impossible by the capacity rule.
  - Completion is not visible to retirement until the next cycle (absent the optional feature).
- flush:
  - Highest priority; overrides alloc, complete and retire in that cycle.
  - All valid=0, head=tail=count=0; retirement outputs all 0 on the next cycle.
  - alloc_ready remains combinational and unaffected.
- Wrap-around: pointers and tags wrap 15->0 with no stall; full=1 with head==tail and count==16.

Optional Feature:
- Macro: ROB_COMPLETE_BYPASS_EN.
- Defined: retirement treats an entry as done if a same-cycle completion hits it, and takes that lane's complete_value. Completion-to-retire latency drops from 2 to 1 cycle.
- Undefined: retirement uses stored done/value only.

Decomposition:
- Shared package ooo_pkg:
  - Constants LANES, ROB_DEPTH, TAG_W, REG_W, DATA_W.
  - Typedefs tag_t, reg_idx_t, data_t, rob_entry_t {valid, done, has_dest, dest_reg, value}.
- Sub-module rob_retire_select (combinational):
  - Inputs: head and the 4 candidate entries (plus bypass inputs).
  - Outputs: per-slot retire mask (prefix-AND) and r.

Test Plan:
1. Reset mid-operation with count=7 -> next cycle occupancy=0, empty=1, all write enables 0.
2. Allocate lanes {1,0,1,1} from tail=14 -> tags 14,15,0; tail=1; occupancy=3.
3. Complete tags 0,14 with 0xBEEF,0x1234 (15 not done) -> one cycle later only slot 0 retires: enable=1, data=0x1234, writer=14, retire_count=1.
4. Full buffer (occupancy=16) requesting 1 alloc while 4 retire -> alloc_ready=0; occupancy becomes 12.
5. Alloc tag 5 with has_dest=0, then complete it -> retires with enable=0, retire_count=1.
6. Flush in the same cycle as allocation and completion -> occupancy=0, no retirement next cycle. With ROB_COMPLETE_BYPASS_EN, complete head at cycle t -> retire outputs at t+1, versus t+2 without.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared constants and types for the out-of-order core's tag, register and result buses.
package ooo_pkg;

  localparam int LANES     = 4;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int REG_W     = 4;
  localparam int DATA_W    = 16;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     has_dest;
    reg_idx_t dest_reg;
    data_t    value;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Retire slot selection: prefix-AND of valid&done over head..head+3, plus retire count.
// Purely combinational; the first slot that cannot retire blocks every later slot.
module rob_retire_select
  import ooo_pkg::*;
(
  input  logic [LANES-1:0] cand_valid,
  input  logic [LANES-1:0] cand_done,
  input  logic [LANES-1:0] byp_done,
  output logic [LANES-1:0] mask,
  output logic [2:0]       r
);

  always_comb begin
    logic run;
    run  = 1'b1;
    r    = '0;
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      run     = run & cand_valid[i] & (cand_done[i] | byp_done[i]);
      mask[i] = run;
      r       = r + {2'b0, run};
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry, 4-wide in-order commit ROB; retire outputs registered (1 cycle). ROB_COMPLETE_BYPASS_EN lets same-cycle completions retire.
// Backpressure: alloc_ready drops (all-or-nothing) when start-of-cycle count plus requests exceeds capacity.
module reorder_buffer
  import ooo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_valid                  [LANES],
  input  logic       alloc_has_dest               [LANES],
  input  reg_idx_t   alloc_dest_reg               [LANES],
  output logic       alloc_ready,
  output tag_t       alloc_tag                    [LANES],
  input  logic       complete_valid               [LANES],
  input  tag_t       complete_tag                 [LANES],
  input  data_t      complete_value               [LANES],
  input  logic       flush,
  output logic       retirement_write_data_enable [LANES],
  output reg_idx_t   retirement_target_reg        [LANES],
  output data_t      retirement_write_data        [LANES],
  output tag_t       instruction_writer           [LANES],
  output logic [2:0] retire_count,
  output logic [4:0] occupancy,
  output logic       empty,
  output logic       full
);

  rob_entry_t       rob [ROB_DEPTH];
  tag_t             head, tail;
  logic [4:0]       count;
  logic [2:0]       n_alloc;
  logic [2:0]       r;
  logic [LANES-1:0] cand_valid, cand_done, byp_done, mask;
  tag_t             slot_tag [LANES];
  data_t            slot_val [LANES];

  // Sparse lanes pack densely: each lane's tag skips only the valid lanes below it.
  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < LANES; k++) begin
      alloc_tag[k] = tail + tag_t'(n_alloc);
      n_alloc      = n_alloc + {2'b0, alloc_valid[k]};
    end
  end

  assign alloc_ready = (count + {2'b0, n_alloc}) <= 5'd16;
  assign occupancy   = count;
  assign empty       = (count == 5'd0);
  assign full        = count[4];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      slot_tag[i]   = head + tag_t'(i);
      cand_valid[i] = rob[slot_tag[i]].valid;
      cand_done[i]  = rob[slot_tag[i]].done;
      byp_done[i]   = 1'b0;
      slot_val[i]   = rob[slot_tag[i]].value;
`ifdef ROB_COMPLETE_BYPASS_EN
      for (int j = 0; j < LANES; j++) begin
        if (complete_valid[j] && complete_tag[j] == slot_tag[i]) begin
          byp_done[i] = 1'b1;
          slot_val[i] = complete_value[j];
        end
      end
`endif
    end
  end

  rob_retire_select u_sel (
    .cand_valid (cand_valid),
    .cand_done  (cand_done),
    .byp_done   (byp_done),
    .mask       (mask),
    .r          (r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ROB_DEPTH; e++) rob[e] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_count <= '0;
      for (int i = 0; i < LANES; i++) begin
        retirement_write_data_enable[i] <= 1'b0;
        retirement_target_reg[i]        <= '0;
        retirement_write_data[i]        <= '0;
        instruction_writer[i]           <= '0;
      end
    end else if (flush) begin
      for (int e = 0; e < ROB_DEPTH; e++) rob[e].valid <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_count <= '0;
      for (int i = 0; i < LANES; i++) begin
        retirement_write_data_enable[i] <= 1'b0;
        retirement_target_reg[i]        <= '0;
        retirement_write_data[i]        <= '0;
        instruction_writer[i]           <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        retirement_write_data_enable[i] <= mask[i] & rob[slot_tag[i]].has_dest;
        retirement_target_reg[i]        <= mask[i] ? rob[slot_tag[i]].dest_reg : '0;
        retirement_write_data[i]        <= mask[i] ? slot_val[i] : '0;
        instruction_writer[i]           <= mask[i] ? slot_tag[i] : '0;
        if (mask[i]) rob[slot_tag[i]].valid <= 1'b0;
      end
      // Ascending lane order makes the highest lane win on duplicate tags.
      for (int j = 0; j < LANES; j++) begin
        if (complete_valid[j] && rob[complete_tag[j]].valid) begin
          rob[complete_tag[j]].done  <= 1'b1;
          rob[complete_tag[j]].value <= complete_value[j];
        end
      end
      if (alloc_ready) begin
        for (int k = 0; k < LANES; k++) begin
          if (alloc_valid[k])
            rob[alloc_tag[k]] <= '{valid: 1'b1, done: 1'b0, has_dest: alloc_has_dest[k],
                                   dest_reg: alloc_dest_reg[k], value: '0};
        end
        tail <= tail + tag_t'(n_alloc);
      end
      head         <= head + tag_t'(r);
      count        <= count + (alloc_ready ? {2'b0, n_alloc} : 5'd0) - {2'b0, r};
      retire_count <= r;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation, completion, ordered retirement, flush, wrap.
module tb_reorder_buffer;
  import ooo_pkg::*;

`ifdef ROB_COMPLETE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk, rst, flush;
  logic       alloc_valid    [LANES];
  logic       alloc_has_dest [LANES];
  reg_idx_t   alloc_dest_reg [LANES];
  logic       alloc_ready;
  tag_t       alloc_tag      [LANES];
  logic       complete_valid [LANES];
  tag_t       complete_tag   [LANES];
  data_t      complete_value [LANES];
  logic       ret_en         [LANES];
  reg_idx_t   ret_reg        [LANES];
  data_t      ret_data       [LANES];
  tag_t       ret_writer     [LANES];
  logic [2:0] retire_count;
  logic [4:0] occupancy;
  logic       empty, full;

  int tests = 0;
  int fails = 0;

  reorder_buffer dut (
    .clk                          (clk),
    .rst                          (rst),
    .alloc_valid                  (alloc_valid),
    .alloc_has_dest               (alloc_has_dest),
    .alloc_dest_reg               (alloc_dest_reg),
    .alloc_ready                  (alloc_ready),
    .alloc_tag                    (alloc_tag),
    .complete_valid               (complete_valid),
    .complete_tag                 (complete_tag),
    .complete_value               (complete_value),
    .flush                        (flush),
    .retirement_write_data_enable (ret_en),
    .retirement_target_reg        (ret_reg),
    .retirement_write_data        (ret_data),
    .instruction_writer           (ret_writer),
    .retire_count                 (retire_count),
    .occupancy                    (occupancy),
    .empty                        (empty),
    .full                         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_alloc;
    for (int k = 0; k < LANES; k++) begin
      alloc_valid[k]    = 1'b0;
      alloc_has_dest[k] = 1'b0;
      alloc_dest_reg[k] = '0;
    end
  endtask

  task automatic clear_complete;
    for (int k = 0; k < LANES; k++) begin
      complete_valid[k] = 1'b0;
      complete_tag[k]   = '0;
      complete_value[k] = '0;
    end
  endtask

  // Completion inputs must already be driven; returns cycles until retire_count goes non-zero.
  task automatic wait_retire(input int max, output int cyc);
    tick;
    clear_complete;
    cyc = 1;
    while (retire_count == 3'd0 && cyc < max) begin
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    tests++; if (occupancy !== 5'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b exp 0", full); end
    tests++; if (retire_count !== 3'd0) begin fails++; $display("FAIL reset_rcnt got %0d exp 0", retire_count); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
    for (int i = 0; i < LANES; i++) begin
      tests++; if (ret_en[i] !== 1'b0) begin fails++; $display("FAIL reset_en%0d got %0b exp 0", i, ret_en[i]); end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < LANES; k++) begin alloc_valid[k] = 1'b1; alloc_has_dest[k] = 1'b1; end
    tick;
    alloc_valid[3] = 1'b0;
    tick;
    clear_alloc;
    #1;
    tests++; if (occupancy !== 5'd7) begin fails++; $display("FAIL mid_occ7 got %0d exp 7", occupancy); end
    rst = 1'b1;
    #1;
    tests++; if (occupancy !== 5'd0) begin fails++; $display("FAIL mid_rst_occ got %0d exp 0", occupancy); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_rst_empty got %0b exp 1", empty); end
    tick;
    rst = 1'b0;
    #1;
    tests++; if (ret_en[0] !== 1'b0 || retire_count !== 3'd0) begin fails++; $display("FAIL mid_rst_ret got en %0b cnt %0d exp 0 0", ret_en[0], retire_count); end
    tests++; if (alloc_tag[0] !== 4'd0) begin fails++; $display("FAIL mid_rst_tail got %0d exp 0", alloc_tag[0]); end
  endtask

  task automatic test_fill_wrap;
    int c;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < LANES; k++) begin
        alloc_valid[k]    = (b * 4 + k) < 14;
        alloc_has_dest[k] = 1'b1;
      end
      tick;
    end
    clear_alloc;
    #1;
    tests++; if (occupancy !== 5'd14) begin fails++; $display("FAIL fill_occ got %0d exp 14", occupancy); end
    tests++; if (alloc_tag[0] !== 4'd14) begin fails++; $display("FAIL fill_tail got %0d exp 14", alloc_tag[0]); end
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < LANES; k++) begin
        complete_valid[k] = (b * 4 + k) < 14;
        complete_tag[k]   = tag_t'(b * 4 + k);
        complete_value[k] = data_t'(b * 4 + k);
      end
      tick;
    end
    clear_complete;
    c = 0;
    while (empty !== 1'b1 && c < 10) begin tick; c++; end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fill_drain got occ %0d exp 0", occupancy); end
  endtask

  task automatic test_alloc_sparse;
    alloc_valid    = '{1'b1, 1'b0, 1'b1, 1'b1};
    alloc_has_dest = '{1'b1, 1'b0, 1'b1, 1'b1};
    alloc_dest_reg = '{4'd3, 4'd0, 4'd5, 4'd7};
    #1;
    tests++; if (alloc_tag[0] !== 4'd14) begin fails++; $display("FAIL sparse_tag0 got %0d exp 14", alloc_tag[0]); end
    tests++; if (alloc_tag[2] !== 4'd15) begin fails++; $display("FAIL sparse_tag2 got %0d exp 15", alloc_tag[2]); end
    tests++; if (alloc_tag[3] !== 4'd0) begin fails++; $display("FAIL sparse_tag3 got %0d exp 0", alloc_tag[3]); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL sparse_ready got %0b exp 1", alloc_ready); end
    tick;
    clear_alloc;
    #1;
    tests++; if (occupancy !== 5'd3) begin fails++; $display("FAIL sparse_occ got %0d exp 3", occupancy); end
    tests++; if (alloc_tag[0] !== 4'd1) begin fails++; $display("FAIL sparse_tail got %0d exp 1", alloc_tag[0]); end
  endtask

  task automatic test_complete_partial;
    int cyc;
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd0;  complete_value[0] = 16'hBEEF;
    complete_valid[1] = 1'b1; complete_tag[1] = 4'd14; complete_value[1] = 16'h1234;
    wait_retire(5, cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL part_lat got %0d exp %0d", cyc, LAT); end
    tests++; if (retire_count !== 3'd1) begin fails++; $display("FAIL part_rcnt got %0d exp 1", retire_count); end
    tests++; if (ret_en[0] !== 1'b1 || ret_data[0] !== 16'h1234 || ret_writer[0] !== 4'd14 || ret_reg[0] !== 4'd3) begin
      fails++; $display("FAIL part_slot0 got en %0b data %h wr %0d reg %0d exp 1 1234 14 3", ret_en[0], ret_data[0], ret_writer[0], ret_reg[0]); end
    tests++; if (ret_en[1] !== 1'b0 || ret_data[1] !== 16'h0) begin fails++; $display("FAIL part_slot1 got en %0b data %h exp 0 0", ret_en[1], ret_data[1]); end
    tick;
    tests++; if (retire_count !== 3'd0 || occupancy !== 5'd2) begin fails++; $display("FAIL part_block got cnt %0d occ %0d exp 0 2", retire_count, occupancy); end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd15; complete_value[0] = 16'hAAAA;
    wait_retire(5, cyc);
    tests++; if (retire_count !== 3'd2) begin fails++; $display("FAIL wrap_rcnt got %0d exp 2", retire_count); end
    tests++; if (ret_writer[0] !== 4'd15 || ret_data[0] !== 16'hAAAA || ret_reg[0] !== 4'd5) begin
      fails++; $display("FAIL wrap_slot0 got wr %0d data %h reg %0d exp 15 aaaa 5", ret_writer[0], ret_data[0], ret_reg[0]); end
    tests++; if (ret_writer[1] !== 4'd0 || ret_data[1] !== 16'hBEEF || ret_reg[1] !== 4'd7 || ret_en[1] !== 1'b1) begin
      fails++; $display("FAIL wrap_slot1 got wr %0d data %h reg %0d en %0b exp 0 beef 7 1", ret_writer[1], ret_data[1], ret_reg[1], ret_en[1]); end
    tests++; if (occupancy !== 5'd0) begin fails++; $display("FAIL wrap_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    for (int k = 0; k < LANES; k++) begin
      alloc_valid[k] = 1'b1; alloc_has_dest[k] = 1'b1; alloc_dest_reg[k] = reg_idx_t'(8 + k);
    end
    tick;
    clear_alloc;
    for (int k = 0; k < LANES; k++) begin
      complete_valid[k] = 1'b1; complete_tag[k] = tag_t'(1 + k); complete_value[k] = data_t'(16'h0100 + k);
    end
    wait_retire(5, cyc);
    tests++; if (retire_count !== 3'd4) begin fails++; $display("FAIL b2b_rcnt got %0d exp 4", retire_count); end
    for (int k = 0; k < LANES; k++) begin
      tests++; if (ret_writer[k] !== tag_t'(1 + k) || ret_data[k] !== data_t'(16'h0100 + k) || ret_en[k] !== 1'b1) begin
        fails++; $display("FAIL b2b_slot%0d got wr %0d data %h en %0b exp %0d %h 1", k, ret_writer[k], ret_data[k], ret_en[k], 1 + k, 16'h0100 + k); end
    end
    alloc_valid[0] = 1'b1; alloc_has_dest[0] = 1'b0; alloc_dest_reg[0] = 4'd9;
    #1;
    tests++; if (alloc_tag[0] !== 4'd5) begin fails++; $display("FAIL nodest_tag got %0d exp 5", alloc_tag[0]); end
    tick;
    clear_alloc;
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd5; complete_value[0] = 16'h55AA;
    wait_retire(5, cyc);
    tests++; if (retire_count !== 3'd1 || ret_en[0] !== 1'b0) begin fails++; $display("FAIL nodest_ret got cnt %0d en %0b exp 1 0", retire_count, ret_en[0]); end
    tests++; if (ret_writer[0] !== 4'd5 || ret_data[0] !== 16'h55AA || ret_reg[0] !== 4'd9) begin
      fails++; $display("FAIL nodest_slot got wr %0d data %h reg %0d exp 5 55aa 9", ret_writer[0], ret_data[0], ret_reg[0]); end
  endtask

  task automatic test_full;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < LANES; k++) alloc_valid[k] = 1'b1;
      tick;
    end
    clear_alloc;
    #1;
    tests++; if (full !== 1'b1 || occupancy !== 5'd16 || empty !== 1'b0) begin
      fails++; $display("FAIL full_flags got full %0b occ %0d empty %0b exp 1 16 0", full, occupancy, empty); end
    for (int k = 0; k < LANES; k++) begin
      complete_valid[k] = 1'b1; complete_tag[k] = tag_t'(6 + k); complete_value[k] = data_t'(k);
    end
`ifndef ROB_COMPLETE_BYPASS_EN
    tick;
    clear_complete;
`endif
    alloc_valid[0] = 1'b1;
    #1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
    tick;
    clear_alloc;
    clear_complete;
    #1;
    tests++; if (occupancy !== 5'd12 || retire_count !== 3'd4 || full !== 1'b0) begin
      fails++; $display("FAIL full_retire got occ %0d cnt %0d full %0b exp 12 4 0", occupancy, retire_count, full); end
    tests++; if (alloc_tag[0] !== 4'd6) begin fails++; $display("FAIL full_tail got %0d exp 6", alloc_tag[0]); end
  endtask

  task automatic test_flush;
    alloc_valid[0] = 1'b1;
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd10; complete_value[0] = 16'h7777;
    flush = 1'b1;
    #1;
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %0b exp 1", alloc_ready); end
    tick;
    flush = 1'b0;
    clear_alloc;
    clear_complete;
    #1;
    tests++; if (occupancy !== 5'd0 || empty !== 1'b1 || retire_count !== 3'd0) begin
      fails++; $display("FAIL flush_state got occ %0d empty %0b cnt %0d exp 0 1 0", occupancy, empty, retire_count); end
    tests++; if (alloc_tag[0] !== 4'd0) begin fails++; $display("FAIL flush_tail got %0d exp 0", alloc_tag[0]); end
    tick;
    tests++; if (retire_count !== 3'd0 || ret_en[0] !== 1'b0) begin fails++; $display("FAIL flush_next got cnt %0d en %0b exp 0 0", retire_count, ret_en[0]); end
  endtask

  task automatic test_latency;
    alloc_valid[0] = 1'b1; alloc_has_dest[0] = 1'b1; alloc_dest_reg[0] = 4'd2;
    tick;
    clear_alloc;
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd0; complete_value[0] = 16'h0F0F;
    tick;
    clear_complete;
`ifdef ROB_COMPLETE_BYPASS_EN
    tests++; if (retire_count !== 3'd1 || ret_data[0] !== 16'h0F0F) begin fails++; $display("FAIL lat_t1 got cnt %0d data %h exp 1 0f0f", retire_count, ret_data[0]); end
    tick;
    tests++; if (retire_count !== 3'd0) begin fails++; $display("FAIL lat_t2 got cnt %0d exp 0", retire_count); end
`else
    tests++; if (retire_count !== 3'd0) begin fails++; $display("FAIL lat_t1 got cnt %0d exp 0", retire_count); end
    tick;
    tests++; if (retire_count !== 3'd1 || ret_data[0] !== 16'h0F0F || ret_reg[0] !== 4'd2) begin
      fails++; $display("FAIL lat_t2 got cnt %0d data %h reg %0d exp 1 0f0f 2", retire_count, ret_data[0], ret_reg[0]); end
`endif
  endtask

  task automatic test_invalid_and_dup;
    int cyc;
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd1; complete_value[0] = 16'hDEAD;
    tick;
    clear_complete;
    alloc_valid[0] = 1'b1; alloc_has_dest[0] = 1'b1; alloc_dest_reg[0] = 4'd4;
    tick;
    clear_alloc;
    tick;
    tick;
    tests++; if (retire_count !== 3'd0 || occupancy !== 5'd1) begin fails++; $display("FAIL inval_ignored got cnt %0d occ %0d exp 0 1", retire_count, occupancy); end
    complete_valid[0] = 1'b1; complete_tag[0] = 4'd1; complete_value[0] = 16'h1111;
    complete_valid[2] = 1'b1; complete_tag[2] = 4'd1; complete_value[2] = 16'h2222;
    wait_retire(5, cyc);
    tests++; if (retire_count !== 3'd1 || ret_data[0] !== 16'h2222 || ret_writer[0] !== 4'd1) begin
      fails++; $display("FAIL dup_lane got cnt %0d data %h wr %0d exp 1 2222 1", retire_count, ret_data[0], ret_writer[0]); end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    clear_alloc;
    clear_complete;
    tick;
    tick;
    test_reset;
    rst = 1'b0;
    tick;
    test_reset_mid;
    test_fill_wrap;
    test_alloc_sparse;
    test_complete_partial;
    test_back_to_back;
    test_full;
    test_flush;
    test_latency;
    test_invalid_and_dup;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
